fp_div_seq: RTL and testbench

FP_DIV_SEQ -- requirements
Module: fp_div_seq

---
 rtl/fp_pkg.sv | 22 ++
 rtl/fp_div_sat.sv | 46 ++++
 rtl/fp_div_seq.sv | 147 ++++++++++++++
 tb/tb_fp_div_seq.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the sequential fixed-point divider: FSM encoding and
// the shift/iteration-count helpers.
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Left shift applied to |in1| so the quotient lands on WFO fraction bits.
    function automatic int calc_s(input int wf1, input int wf2, input int wfo);
        return wf2 + wfo - wf1;
    endfunction

    // Number of quotient bits produced, one per DIV cycle.
    function automatic int calc_nd(input int wi1, input int wf1, input int wf2, input int wfo);
        return wi1 + wf1 + calc_s(wf1, wf2, wfo);
    endfunction

endpackage

// File: rtl/fp_div_sat.sv
// Applies the result sign to the unsigned quotient magnitude and saturates it
// into the signed output format; also forms the divide-by-zero result.
module fp_div_sat #(
    parameter int unsigned ND = 36,
    parameter int unsigned WO = 24
) (
    input  logic [ND-1:0] q,
    input  logic          neg,
    input  logic          dbz,
    input  logic          dbz_neg,
    output logic [WO-1:0] res,
    output logic          ovf
);

    localparam int unsigned WC = ((ND > WO) ? ND : WO) + 1;

    logic [WC-1:0] qx;
    logic [WC-1:0] maxp;
    logic [WO-1:0] pos_max;
    logic [WO-1:0] neg_min;

    assign qx      = WC'(q);
    assign maxp    = (WC'(1) << (WO - 1)) - WC'(1);
    assign pos_max = {1'b0, {(WO-1){1'b1}}};
    assign neg_min = {1'b1, {(WO-1){1'b0}}};

    // Negative results may reach one step further than positive ones.
    always_comb begin
        res = qx[WO-1:0];
        ovf = 1'b0;
        if (dbz) begin
            res = dbz_neg ? neg_min : pos_max;
        end else if (neg && (qx != '0)) begin
            if (qx > (maxp + WC'(1))) begin
                res = neg_min;
                ovf = 1'b1;
            end else begin
                res = ~qx[WO-1:0] + WO'(1);
            end
        end else if (qx > maxp) begin
            res = pos_max;
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/fp_div_seq.sv
// Sequential signed fixed-point divider: restoring division on magnitudes,
// one quotient bit per cycle, then sign/saturation and a valid/ready output.
module fp_div_seq
    import fp_pkg::*;
#(
    parameter int unsigned WI1 = 4,
    parameter int unsigned WF1 = 16,
    parameter int unsigned WI2 = 4,
    parameter int unsigned WF2 = 16,
    parameter int unsigned WIO = 8,
    parameter int unsigned WFO = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WI1+WF1-1:0]   in1,
    input  logic [WI2+WF2-1:0]   in2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIO+WFO-1:0]   out,
    output logic                 overflow,
    output logic                 div_by_zero
);

    localparam int          S  = calc_s(int'(WF1), int'(WF2), int'(WFO));
    localparam int unsigned ND = calc_nd(int'(WI1), int'(WF1), int'(WF2), int'(WFO));
    localparam int unsigned N1 = WI1 + WF1;
    localparam int unsigned N2 = WI2 + WF2;
    localparam int unsigned WO = WIO + WFO;
    localparam int unsigned CW = $clog2(ND + 1);

    generate
        if (S < 0) begin : g_bad_shift
            $error("fp_div_seq: WF2+WFO must not be smaller than WF1");
        end
    endgenerate

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [ND-1:0] num_q;
    logic [ND-1:0] quo_q;
    logic [N2-1:0] rem_q;
    logic [N2-1:0] dvs_q;
    logic          sgn_q;
    logic          in1_neg_q;
    logic          dbz_q;

    logic [N1-1:0] mag1_c;
    logic [N2-1:0] mag2_c;
    logic [N2:0]   trial_c;
    logic          ge_c;
    logic [N2-1:0] rem_c;
    logic [WO-1:0] sat_res_c;
    logic          sat_ovf_c;
    logic          accept_c;

    assign accept_c = in_valid && in_ready;
    assign mag1_c   = in1[N1-1] ? (~in1 + N1'(1)) : in1;
    assign mag2_c   = in2[N2-1] ? (~in2 + N2'(1)) : in2;

    // Restoring step: bring in the next numerator bit, subtract if it fits.
    assign trial_c = {rem_q, num_q[ND-1]};
    assign ge_c    = trial_c >= {1'b0, dvs_q};
    assign rem_c   = ge_c ? N2'(trial_c - {1'b0, dvs_q}) : trial_c[N2-1:0];

    fp_div_sat #(
        .ND (ND),
        .WO (WO)
    ) u_sat (
        .q       (quo_q),
        .neg     (sgn_q),
        .dbz     (dbz_q),
        .dbz_neg (in1_neg_q),
        .res     (sat_res_c),
        .ovf     (sat_ovf_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = DIV;
            DIV:     if (cnt_q == CW'(ND - 1)) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out         <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            cnt_q       <= '0;
            num_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            dvs_q       <= '0;
            sgn_q       <= 1'b0;
            in1_neg_q   <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            in_ready <= (state_d == IDLE);
            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        num_q     <= ND'(mag1_c) << S;
                        quo_q     <= '0;
                        rem_q     <= '0;
                        dvs_q     <= mag2_c;
                        sgn_q     <= in1[N1-1] ^ in2[N2-1];
                        in1_neg_q <= in1[N1-1];
                        dbz_q     <= (in2 == '0);
                        cnt_q     <= '0;
                    end
                end
                DIV: begin
                    num_q <= num_q << 1;
                    quo_q <= {quo_q[ND-2:0], ge_c};
                    rem_q <= rem_c;
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: begin
                    out         <= sat_res_c;
                    overflow    <= sat_ovf_c;
                    div_by_zero <= dbz_q;
                end
                DONE: begin
                    if (!out_valid)     out_valid <= 1'b1;
                    else if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed and random checks of fp_div_seq at default Q4.16 / Q8.16 formats,
// with a scoreboard of expected results.
module tb_fp_div_seq;

    typedef struct packed {
        logic [23:0] out;
        logic        ovf;
        logic        dbz;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in1;
    logic [19:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out;
    logic        overflow;
    logic        div_by_zero;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    fp_div_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in1         (in1),
        .in2         (in2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [23:0] o, input logic v, input logic z);
        exp_t e;
        e.out = o;
        e.ovf = v;
        e.dbz = z;
        return e;
    endfunction

    // Integer reference: truncating division with the result scaled by 2^16.
    function automatic exp_t model(input logic [19:0] a, input logic [19:0] b);
        longint sa;
        longint sb;
        longint ma;
        longint mb;
        longint q;
        exp_t   e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = mk(24'h0, 1'b0, 1'b0);
        if (sb == 0) begin
            e.dbz = 1'b1;
            e.out = (sa < 0) ? 24'h800000 : 24'h7FFFFF;
        end else begin
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            q  = (ma * 65536) / mb;
            if (((sa < 0) != (sb < 0)) && (q != 0)) begin
                if (q > 64'sd8388608) begin
                    e.out = 24'h800000;
                    e.ovf = 1'b1;
                end else begin
                    e.out = 24'(-q);
                end
            end else if (q > 64'sd8388607) begin
                e.out = 24'h7FFFFF;
                e.ovf = 1'b1;
            end else begin
                e.out = 24'(q);
            end
        end
        return e;
    endfunction

    task automatic run_op(input logic [19:0] a, input logic [19:0] b, input int hold, input exp_t e);
        int          n;
        exp_t        ex;
        logic [23:0] held;
        chk("in_ready_idle", 64'(in_ready), 64'(1));
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in1      = ~a;
        in2      = ~b;
        chk("in_ready_busy", 64'(in_ready), 64'(0));
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(38));
        held = out;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            in1      = 20'h12345;
            in2      = 20'h00100;
            @(posedge clk); #1;
            chk("hold_out", 64'(out), 64'(held));
            chk("hold_in_ready", 64'(in_ready), 64'(0));
            chk("hold_valid", 64'(out_valid), 64'(1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("sb_size", 64'(sb_q.size()), 64'(1));
        if (sb_q.size() > 0) begin
            ex = sb_q.pop_front();
            chk("out", 64'(out), 64'(ex.out));
            chk("overflow", 64'(overflow), 64'(ex.ovf));
            chk("div_by_zero", 64'(div_by_zero), 64'(ex.dbz));
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_valid", 64'(out_valid), 64'(0));
        chk("post_in_ready", 64'(in_ready), 64'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] a;
        logic [19:0] b;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = '0;
        in2       = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out", 64'(out), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        chk("rst_dbz", 64'(div_by_zero), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        run_op(20'h18000, 20'h08000, 0, mk(24'h030000, 1'b0, 1'b0));
        run_op(20'h10000, 20'h30000, 0, mk(24'h005555, 1'b0, 1'b0));
        run_op(20'hF0000, 20'h30000, 0, mk(24'hFFAAAB, 1'b0, 1'b0));
        run_op(20'h70000, 20'h00001, 0, mk(24'h7FFFFF, 1'b1, 1'b0));
        run_op(20'hE0000, 20'h00000, 0, mk(24'h800000, 1'b0, 1'b1));
        run_op(20'h50000, 20'h00000, 0, mk(24'h7FFFFF, 1'b0, 1'b1));
        run_op(20'h80000, 20'h00001, 0, mk(24'h800000, 1'b1, 1'b0));
        run_op(20'h00000, 20'hF0000, 0, mk(24'h000000, 1'b0, 1'b0));
        run_op(20'h10000, 20'hE0000, 10, mk(24'hFF8000, 1'b0, 1'b0));

        // Reset in the middle of a division must drop it silently.
        chk("abort_in_ready", 64'(in_ready), 64'(1));
        in1      = 20'h18000;
        in2      = 20'h08000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 64'(out_valid), 64'(0));
        chk("abort_out", 64'(out), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(20'hF0000, 20'h30000, 0, mk(24'hFFAAAB, 1'b0, 1'b0));

        for (int i = 0; i < 8; i++) begin
            a = 20'($urandom);
            if ((i % 2) == 1) b = 20'($urandom_range(1, 255));
            else              b = 20'($urandom);
            if ($urandom_range(0, 1) == 1) b = -b;
            run_op(a, b, 0, model(a, b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
